// File: rtl/pipe_adder.sv
// Pipelined add/subtract unit: WIDTH-bit add split into STAGES registered carry slices.
// Optional flags ovf/zero/neg are built when ADDER_FLAGS_EN is defined.
module pipe_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry
`ifdef ADDER_FLAGS_EN
    ,
    output logic             ovf,
    output logic             zero,
    output logic             neg
`endif
);

    localparam int SW   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    logic             w_adv;
    logic [WIDTH-1:0] w_beff;
    logic             w_c0;

    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;
    assign w_beff   = sub ? ~b : b;
    assign w_c0     = sub | cin;

    // Stage k keeps result bits [LW-1:0] and only the operand bits still to be added.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LW = (k + 1) * SW;
        localparam int UW = WIDTH - LW;

        logic [SW-1:0] w_as;
        logic [SW-1:0] w_bs;
        logic [SW-1:0] w_slice;
        logic          w_vin;
        logic          w_cin;
        logic          w_cout;
        logic [LW-1:0] w_sum_nx;
        logic          r_vld;
        logic          r_c;
        logic [LW-1:0] r_sum;

        if (k == 0) begin : g_src
            assign w_vin    = in_valid;
            assign w_cin    = w_c0;
            assign w_as     = a[SW-1:0];
            assign w_bs     = w_beff[SW-1:0];
            assign w_sum_nx = w_slice;
        end else begin : g_src
            assign w_vin    = g_stage[k-1].r_vld;
            assign w_cin    = g_stage[k-1].r_c;
            assign w_as     = g_stage[k-1].g_fwd.r_a[SW-1:0];
            assign w_bs     = g_stage[k-1].g_fwd.r_b[SW-1:0];
            assign w_sum_nx = {w_slice, g_stage[k-1].r_sum};
        end

        assign {w_cout, w_slice} = {1'b0, w_as} + {1'b0, w_bs} + {{SW{1'b0}}, w_cin};

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_vld <= 1'b0;
                r_c   <= 1'b0;
                r_sum <= '0;
            end else if (w_adv) begin
                r_vld <= w_vin;
                r_c   <= w_cout;
                r_sum <= w_sum_nx;
            end
        end

        if (UW > 0) begin : g_fwd
            logic [UW-1:0] r_a;
            logic [UW-1:0] r_b;
            logic [UW-1:0] w_a_up;
            logic [UW-1:0] w_b_up;

            if (k == 0) begin : g_up
                assign w_a_up = a[WIDTH-1:SW];
                assign w_b_up = w_beff[WIDTH-1:SW];
            end else begin : g_up
                assign w_a_up = g_stage[k-1].g_fwd.r_a[UW+SW-1:SW];
                assign w_b_up = g_stage[k-1].g_fwd.r_b[UW+SW-1:SW];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_adv) begin
                    r_a <= w_a_up;
                    r_b <= w_b_up;
                end
            end
        end
    end

    assign out_valid = g_stage[LAST].r_vld;
    assign sum       = g_stage[LAST].r_sum;
    assign carry     = g_stage[LAST].r_c;

`ifdef ADDER_FLAGS_EN
    logic             r_ovf;
    logic             r_zero;
    logic             r_neg;
    logic             w_a_msb;
    logic             w_b_msb;
    logic [WIDTH-1:0] w_fsum;

    // The top slice holds the operand MSBs, so flags are formed alongside the final sum.
    assign w_a_msb = g_stage[LAST].w_as[SW-1];
    assign w_b_msb = g_stage[LAST].w_bs[SW-1];
    assign w_fsum  = g_stage[LAST].w_sum_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
            r_neg  <= 1'b0;
        end else if (w_adv) begin
            r_ovf  <= (w_a_msb == w_b_msb) && (w_fsum[WIDTH-1] != w_a_msb);
            r_zero <= (w_fsum == '0);
            r_neg  <= w_fsum[WIDTH-1];
        end
    end

    assign ovf  = r_ovf;
    assign zero = r_zero;
    assign neg  = r_neg;
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder: directed cases on a 32/4 instance, random traffic on 64/8.
module tb_pipe_adder;

    logic        clk;
    logic        rst_n;

    logic        iv0, ir0, cin0, sub0, ov0, or0, c0;
    logic [31:0] a0, b0, s0;
    logic        iv1, ir1, cin1, sub1, ov1, or1, c1;
    logic [63:0] a1, b1, s1;
`ifdef ADDER_FLAGS_EN
    logic        ovf0, zero0, neg0, ovf1, zero1, neg1;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [63:0] s;
        logic        c;
        logic        o;
        logic        z;
        logic        n;
    } exp_t;
    exp_t q[$];

    pipe_adder #(.WIDTH(32), .STAGES(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0),
        .cin(cin0), .sub(sub0), .out_valid(ov0), .out_ready(or0), .sum(s0), .carry(c0)
`ifdef ADDER_FLAGS_EN
        , .ovf(ovf0), .zero(zero0), .neg(neg0)
`endif
    );

    pipe_adder #(.WIDTH(64), .STAGES(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
        .cin(cin1), .sub(sub1), .out_valid(ov1), .out_ready(or1), .sum(s1), .carry(c1)
`ifdef ADDER_FLAGS_EN
        , .ovf(ovf1), .zero(zero1), .neg(neg1)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain two's-complement arithmetic; carry on subtract means no borrow.
    function automatic void model(input logic [63:0] a, input logic [63:0] b, input logic cin,
                                  input logic sub, output exp_t e);
        logic [64:0] u;
        logic [65:0] sr;
        if (sub) begin
            u   = {1'b0, a} - {1'b0, b};
            e.c = (a >= b);
            sr  = {{2{a[63]}}, a} - {{2{b[63]}}, b};
        end else begin
            u   = {1'b0, a} + {1'b0, b} + {64'b0, cin};
            e.c = u[64];
            sr  = {{2{a[63]}}, a} + {{2{b[63]}}, b} + {65'b0, cin};
        end
        e.s = u[63:0];
        e.o = (sr[64] != sr[63]);
        e.z = (u[63:0] == 64'b0);
        e.n = u[63];
    endfunction

    task automatic do_op(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                         input logic tc, input logic ts, input logic [31:0] es,
                         input logic ec, input logic eo, input logic ez, input logic en);
        int n;
        n    = 0;
        a0   = ta;
        b0   = tb;
        cin0 = tc;
        sub0 = ts;
        or0  = 1'b1;
        iv0  = 1'b1;
        check({tag, "_ready"}, ir0, 1);
        do begin
            tick;
            n++;
            if (n == 1) iv0 = 1'b0;
        end while (!ov0 && n < 20);
        check({tag, "_latency"}, n, 4);
        check({tag, "_sum"}, s0, es);
        check({tag, "_carry"}, c0, ec);
`ifdef ADDER_FLAGS_EN
        check({tag, "_ovf"}, ovf0, eo);
        check({tag, "_zero"}, zero0, ez);
        check({tag, "_neg"}, neg0, en);
`else
        if (eo || ez || en) begin end
`endif
    endtask

    initial begin
        int   next, got, sent, recv, cyc;
        bit   pending;
        exp_t e, f;

        rst_n = 1'b0;
        iv0 = 0; a0 = '0; b0 = '0; cin0 = 0; sub0 = 0; or0 = 1;
        iv1 = 0; a1 = '0; b1 = '0; cin1 = 0; sub1 = 0; or1 = 1;
        tick;
        tick;
        check("rst_ov0", ov0, 0);
        check("rst_sum0", s0, 0);
        check("rst_carry0", c0, 0);
        check("rst_ready0", ir0, 1);
        check("rst_ov1", ov1, 0);
        check("rst_sum1", s1, 0);
`ifdef ADDER_FLAGS_EN
        check("rst_flags0", {ovf0, zero0, neg0}, 0);
`endif
        rst_n = 1'b1;
        tick;

        do_op("t1", 32'hFFFF_FFFF, 32'h1, 0, 0, 32'h0, 1, 0, 1, 0);
        do_op("t2", 32'h7FFF_FFFF, 32'h1, 0, 0, 32'h8000_0000, 0, 1, 0, 1);
        do_op("t3", 32'h5, 32'h7, 1, 1, 32'hFFFF_FFFE, 0, 0, 0, 1);
        tick;

        // Eight back-to-back ops with a three-cycle consumer stall.
        next = 1;
        got  = 0;
        sub0 = 0;
        cin0 = 0;
        for (int c = 0; c < 30; c++) begin
            or0 = !(c >= 6 && c <= 8);
            a0  = next;
            b0  = next;
            iv0 = (next <= 8);
            #4;
            if (c <= 12) check("t4_ready", ir0, (c < 6 || c > 8));
            if (ov0) begin
                check("t4_sum", s0, 2 * (got + 1));
                if (or0) got++;
            end
            if (iv0 && ir0) next++;
            tick;
        end
        check("t4_count", got, 8);
        or0 = 1;

        // Reset in the middle of a cycle with operations in flight.
        iv0 = 1;
        for (int i = 0; i < 3; i++) begin
            a0 = 100 + i;
            b0 = i;
            tick;
        end
        iv0 = 0;
        tick;
        check("t5_pre_valid", ov0, 1);
        check("t5_pre_sum", s0, 100);
        #3;
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", ov0, 0);
        check("t5_rst_sum", s0, 0);
        check("t5_rst_carry", c0, 0);
        tick;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("t5_no_stale", ov0, 0);
            tick;
        end
        do_op("t5_next", 32'd3, 32'd4, 0, 0, 32'd7, 0, 0, 0, 0);
        tick;

        // Random traffic on the 64-bit, 8-stage instance against the reference model.
        sent    = 0;
        recv    = 0;
        cyc     = 0;
        pending = 0;
        while (recv < 1000 && cyc < 20000) begin
            if (!pending) begin
                if (sent < 1000 && $urandom_range(0, 3) != 0) begin
                    a1   = {$urandom, $urandom};
                    b1   = {$urandom, $urandom};
                    cin1 = $urandom_range(0, 1);
                    sub1 = $urandom_range(0, 1);
                    case ($urandom_range(0, 7))
                        0: b1 = a1;
                        1: a1 = '1;
                        2: b1 = 64'h1;
                        default: ;
                    endcase
                    iv1     = 1;
                    pending = 1;
                end else begin
                    iv1 = 0;
                end
            end
            or1 = ($urandom_range(0, 3) != 0);
            #4;
            if (iv1 && ir1) begin
                model(a1, b1, cin1, sub1, e);
                q.push_back(e);
                sent++;
                pending = 0;
            end
            if (ov1) begin
                if (q.size() == 0) begin
                    check("t6_spurious_valid", ov1, 0);
                end else begin
                    f = q[0];
                    check("t6_sum", s1, f.s);
                    check("t6_carry", c1, f.c);
`ifdef ADDER_FLAGS_EN
                    check("t6_flags", {ovf1, zero1, neg1}, {f.o, f.z, f.n});
`endif
                    if (or1) begin
                        void'(q.pop_front());
                        recv++;
                    end
                end
            end
            tick;
            cyc++;
        end
        iv1 = 0;
        check("t6_received", recv, 1000);
        check("t6_leftover", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
